// File: rtl/mpy_pkg.sv
// Shared types and helpers for the round-robin serial multiplier scheduler.
package mpy_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int MPY_WIDTH = 32;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mpy_serial_core.sv
// Serial multiplier, one iteration per cycle; unsigned shift-add by default,
// radix-2 Booth on two's-complement operands when MPY_BOOTH_EN is defined.
module mpy_serial_core
  import mpy_pkg::*;
#(
  parameter int WIDTH = MPY_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               run_q, run_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   mc_q;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d, addend, sum;
  logic [2*WIDTH-1:0] product_q;
`ifdef MPY_BOOTH_EN
  logic               q_q, q_d;
`endif

  assign last_o    = run_q && (cnt_q == CW'(1));
  assign product_o = product_q;

  // acc carries one extra bit so the add never loses its carry/sign.
  always_comb begin
    addend = '0;
`ifdef MPY_BOOTH_EN
    case ({mplier_q[0], q_q})
      2'b01:   addend = {mc_q[WIDTH-1], mc_q};
      2'b10:   addend = -{mc_q[WIDTH-1], mc_q};
      default: addend = '0;
    endcase
    sum   = acc_q + addend;
    acc_d = {sum[WIDTH], sum[WIDTH:1]};
    q_d   = mplier_q[0];
`else
    if (mplier_q[0]) addend = {1'b0, mc_q};
    sum   = acc_q + addend;
    acc_d = {1'b0, sum[WIDTH:1]};
`endif
    mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
  end

  always_comb begin
    run_d = run_q;
    cnt_d = cnt_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = CW'(WIDTH);
    end else if (run_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      run_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      if (last_o) product_q <= {acc_d[WIDTH-1:0], mplier_d};
    end
  end

  // Datapath registers are always loaded by start before use.
  always_ff @(posedge clk_i) begin
    if (start_i) begin
      mc_q     <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
`ifdef MPY_BOOTH_EN
      q_q      <= 1'b0;
`endif
    end else if (run_q) begin
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
`ifdef MPY_BOOTH_EN
      q_q      <= q_d;
`endif
    end
  end

endmodule

// File: rtl/mpy_sched.sv
// Round-robin arbiter sharing one serial multiplier among NREQ requesters.
// Define MPY_BOOTH_EN for signed (Booth) products; default is unsigned.
module mpy_sched
  import mpy_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = MPY_WIDTH
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   in_a,
  input  logic [NREQ*WIDTH-1:0]   in_b,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic [2*WIDTH-1:0]      Product,
  output logic [id_w(NREQ)-1:0]   Product_Id,
  output logic                    Product_Valid
);

  localparam int IDW = id_w(NREQ);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [IDW-1:0]   win_id_q, win_id_d, rr_ptr_q, rr_ptr_d, pid_q, pid_d;
  logic [IDW-1:0]   sel_id;
  logic [IDW:0]     cand;
  logic             sel_found, start, core_last;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = in_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = in_b[i*WIDTH +: WIDTH];
  end

  // Scan from rr_ptr upward with wrap; first requester found wins.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!sel_found && req[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_id    = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    grant_d  = '0;
    win_id_d = win_id_q;
    pid_d    = pid_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      IDLE: if (sel_found) begin
        start    = 1'b1;
        grant_d  = {{(NREQ-1){1'b0}}, 1'b1} << sel_id;
        win_id_d = sel_id;
        state_d  = RUN;
      end
      RUN: if (core_last) begin
        pid_d   = win_id_q;
        state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = (win_id_q == IDW'(NREQ-1)) ? '0 : win_id_q + IDW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      win_id_q <= '0;
      rr_ptr_q <= '0;
      pid_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      win_id_q <= win_id_d;
      rr_ptr_q <= rr_ptr_d;
      pid_q    <= pid_d;
    end
  end

  mpy_serial_core #(.WIDTH(WIDTH)) u_core (
    .clk_i     (CLK),
    .rst_n_i   (RST),
    .start_i   (start),
    .mcand_i   (a_arr[sel_id]),
    .mplier_i  (b_arr[sel_id]),
    .last_o    (core_last),
    .product_o (Product)
  );

  assign grant         = grant_q;
  assign busy          = (state_q != IDLE);
  assign Product_Valid = (state_q == DONE);
  assign Product_Id    = pid_q;

endmodule

// File: tb/tb_mpy_sched.sv
// Directed, table-driven bench for mpy_sched (NREQ=4, WIDTH=32).
module tb_mpy_sched;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [3:0]    req;
  logic [127:0]  in_a, in_b;
  logic [3:0]    grant;
  logic          busy;
  logic [63:0]   Product;
  logic [1:0]    Product_Id;
  logic          Product_Valid;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int pv_cnt = 0;
  logic overlap = 1'b0;

  mpy_sched #(.NREQ(4), .WIDTH(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req           (req),
    .in_a          (in_a),
    .in_b          (in_b),
    .grant         (grant),
    .busy          (busy),
    .Product       (Product),
    .Product_Id    (Product_Id),
    .Product_Valid (Product_Valid)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (Product_Valid) pv_cnt <= pv_cnt + 1;
    if (Product_Valid && grant != 4'b0) overlap <= 1'b1;
  end

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_pv(output int n);
    n = 0;
    while (!Product_Valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int idx);
    int n;
    string t;
    t = $sformatf("vec%0d", idx);
    in_a[id*32 +: 32] = a;
    in_b[id*32 +: 32] = b;
    req[id] = 1'b1;
    step();
    chk({t, "_grant"}, 64'(grant), 64'(4'b0001 << id));
    chk({t, "_busy"}, 64'(busy), 64'd1);
    req[id] = 1'b0;
    wait_pv(n);
    chk({t, "_latency"}, 64'(n), 64'd32);
    chk({t, "_product"}, Product, exp);
    chk({t, "_id"}, 64'(Product_Id), 64'(id));
    step();
    chk({t, "_pv_pulse"}, 64'(Product_Valid), 64'd0);
    chk({t, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n, g, gcyc, prev_gcyc, pv_before;
    req  = '0;
    in_a = '0;
    in_b = '0;

    vt[0] = '{1, 32'd3,          32'd5,          64'd15};
    vt[1] = '{0, 32'h0000_1234,  32'd0,          64'd0};
`ifdef MPY_BOOTH_EN
    vt[2] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'd1};
    vt[4] = '{0, 32'd7,          32'hFFFF_FFFD,  64'hFFFF_FFFF_FFFF_FFEB};
    vt[5] = '{2, 32'hFFFF_FFFF,  32'd1,          64'hFFFF_FFFF_FFFF_FFFF};
`else
    vt[2] = '{2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vt[4] = '{0, 32'd7,          32'hFFFF_FFFD,  64'h0000_0006_FFFF_FFEB};
    vt[5] = '{2, 32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
`endif
    vt[3] = '{3, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vt[6] = '{3, 32'd12345,      32'd1000,       64'd12345000};
    vt[7] = '{1, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};

    // Reset state
    repeat (2) step();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_product", Product, 64'd0);
    chk("rst_id", 64'(Product_Id), 64'd0);
    chk("rst_pv", 64'(Product_Valid), 64'd0);
    RST = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_one(vt[i].id, vt[i].a, vt[i].b, vt[i].p, i);

    // Abort mid-RUN with reset; last winner was 1 so rr_ptr sits at 2 now
    in_a[64 +: 32] = 32'd5;
    in_b[64 +: 32] = 32'd6;
    req[2] = 1'b1;
    step();
    chk("abort_grant", 64'(grant), 64'h4);
    req[2] = 1'b0;
    repeat (10) step();
    pv_before = pv_cnt;
    #2 RST = 1'b0;
    step();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", Product, 64'd0);
    chk("abort_id", 64'(Product_Id), 64'd0);
    chk("abort_grant_clr", 64'(grant), 64'd0);
    #2 RST = 1'b1;
    repeat (40) step();
    chk("abort_no_pv", 64'(pv_cnt - pv_before), 64'd0);

    // Fairness: all requesting, rr_ptr restarted at 0
    for (int i = 0; i < 4; i++) begin
      in_a[i*32 +: 32] = 32'(i + 2);
      in_b[i*32 +: 32] = 32'(1000 + i);
    end
    req = 4'b1111;
    prev_gcyc = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (grant == 4'b0 && n < 40) begin
        step();
        n++;
      end
      gcyc = cyc;
      g = k % 4;
      chk($sformatf("rr_grant%0d", k), 64'(grant), 64'(4'b0001 << g));
      if (k > 0) chk($sformatf("rr_spacing%0d", k), 64'(gcyc - prev_gcyc), 64'd34);
      prev_gcyc = gcyc;
      req[g] = 1'b0;
      step();
      if (k < 4) req[g] = 1'b1;
      else req = 4'b0;
      wait_pv(n);
      chk($sformatf("rr_id%0d", k), 64'(Product_Id), 64'(g));
      chk($sformatf("rr_prod%0d", k), Product, 64'((g + 2) * (1000 + g)));
      step();
    end

    // Late operand/request changes during RUN are ignored
    in_a[96 +: 32] = 32'd100;
    in_b[96 +: 32] = 32'd3;
    in_a[0 +: 32]  = 32'd11;
    in_b[0 +: 32]  = 32'd13;
    req[3] = 1'b1;
    step();
    chk("late_grant", 64'(grant), 64'h8);
    req[3] = 1'b0;
    in_a[96 +: 32] = 32'd999;
    in_b[96 +: 32] = 32'd7;
    step();
    req[3] = 1'b1;
    req[0] = 1'b1;
    n = 0;
    g = 0;
    while (!Product_Valid && n < 40) begin
      step();
      n++;
      if (grant != 4'b0) g++;
    end
    chk("late_extra_grants", 64'(g), 64'd0);
    chk("late_product", Product, 64'd300);
    chk("late_id", 64'(Product_Id), 64'd3);
    step();
    chk("late_idle_no_grant", 64'(grant), 64'd0);
    step();
    chk("late_next_grant", 64'(grant), 64'h1);
    req = 4'b0;
    wait_pv(n);
    chk("late_next_latency", 64'(n), 64'd32);
    chk("late_next_product", Product, 64'd143);
    chk("late_next_id", 64'(Product_Id), 64'd0);
    step();

    chk("grant_pv_overlap", 64'(overlap), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
